// File: rtl/adc_frame_fifo.sv
// Pairs left/right ADC words captured on LR clock edges and buffers the stereo
// pairs in a first-word-fall-through FIFO towards the audio processing logic.
module adc_frame_fifo #(
   parameter int SAMPLE_W = 24,
   parameter int DEPTH    = 4,
   parameter int LVL_W    = 3
) (
   input  logic                clk,
   input  logic                enable,
   input  logic                adc_lr,
   input  logic [32:0]         SADCL,
   input  logic [32:0]         SADCR,
   input  logic                sample_ready,
   input  logic                overflow_clr,
   output logic [SAMPLE_W-1:0] sample_l,
   output logic [SAMPLE_W-1:0] sample_r,
   output logic                sample_valid,
   output logic [LVL_W-1:0]    fifo_level,
   output logic                overflow
);
   localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int PAIR_W = 2 * SAMPLE_W;

   logic                lr_q, lr_d;
   logic                armed_q, armed_d;
   logic                left_held_q, left_held_d;
   logic [SAMPLE_W-1:0] hold_l_q, hold_l_d;
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]    level_q, level_d;
   logic                overflow_q, overflow_d;
   logic [PAIR_W-1:0]   mem_q [DEPTH];
   logic [PAIR_W-1:0]   mem_d [DEPTH];

   logic rise, fall, pop, push_req, push_ok, drop;
   logic unused_bits;

   // The delay slot (bit 32) and bits below the kept sample are not needed.
   assign unused_bits = ^{SADCL, SADCR};

   // sample_valid/sample_ready: a pair transfers on every posedge where both
   // are high; while valid is high and ready low the head pair holds stable.
   always_comb begin
      rise     = adc_lr & ~lr_q;
      fall     = ~adc_lr & lr_q;
      pop      = (level_q != '0) & sample_ready;
      push_req = fall & left_held_q;
      push_ok  = push_req & ((level_q < LVL_W'(DEPTH)) | pop);
      drop     = push_req & ~push_ok;
   end

   always_comb begin
      lr_d        = adc_lr;
      armed_d     = armed_q | fall;
      hold_l_d    = hold_l_q;
      left_held_d = left_held_q;
      if (rise && armed_q) begin
         hold_l_d    = SADCL[31 -: SAMPLE_W];
         left_held_d = 1'b1;
      end else if (fall) begin
         left_held_d = 1'b0;
      end
   end

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = {hold_l_q, SADCR[31 -: SAMPLE_W]};
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push_ok && !pop) begin
         level_d = level_q + LVL_W'(1);
      end else if (pop && !push_ok) begin
         level_d = level_q - LVL_W'(1);
      end
      // A drop in the same cycle as a clear leaves the flag set.
      overflow_d = drop | (overflow_q & ~overflow_clr);
   end

   always_ff @(posedge clk or negedge enable) begin
      if (!enable) begin
         lr_q        <= 1'b1;
         armed_q     <= 1'b0;
         left_held_q <= 1'b0;
         hold_l_q    <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         overflow_q  <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         lr_q        <= lr_d;
         armed_q     <= armed_d;
         left_held_q <= left_held_d;
         hold_l_q    <= hold_l_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         overflow_q  <= overflow_d;
         mem_q       <= mem_d;
      end
   end

   always_comb begin
      sample_l     = mem_q[rd_ptr_q][PAIR_W-1:SAMPLE_W];
      sample_r     = mem_q[rd_ptr_q][SAMPLE_W-1:0];
      sample_valid = (level_q != '0);
      fifo_level   = level_q;
      overflow     = overflow_q;
   end

endmodule

// File: tb/tb_adc_frame_fifo.sv
// Directed bench for adc_frame_fifo: a 24-bit/depth-4 instance plus a
// 16-bit/depth-2 instance sharing the LR clock and shift registers.
module tb_adc_frame_fifo;
   logic        clk = 1'b0;
   logic        enable;
   logic        adc_lr;
   logic [32:0] SADCL, SADCR;
   logic        sample_ready, overflow_clr;
   logic [23:0] sample_l, sample_r;
   logic        sample_valid, overflow;
   logic [2:0]  fifo_level;

   logic        sample_ready2, overflow_clr2;
   logic [15:0] sample_l2, sample_r2;
   logic        sample_valid2, overflow2;
   logic [1:0]  fifo_level2;

   int n_tests = 0;
   int n_fail  = 0;
   logic [47:0] exp_q[$];

   always #5 clk = ~clk;

   adc_frame_fifo #(.SAMPLE_W(24), .DEPTH(4), .LVL_W(3)) dut (
      .clk(clk), .enable(enable), .adc_lr(adc_lr), .SADCL(SADCL), .SADCR(SADCR),
      .sample_ready(sample_ready), .overflow_clr(overflow_clr),
      .sample_l(sample_l), .sample_r(sample_r), .sample_valid(sample_valid),
      .fifo_level(fifo_level), .overflow(overflow)
   );

   adc_frame_fifo #(.SAMPLE_W(16), .DEPTH(2), .LVL_W(2)) dut16 (
      .clk(clk), .enable(enable), .adc_lr(adc_lr), .SADCL(SADCL), .SADCR(SADCR),
      .sample_ready(sample_ready2), .overflow_clr(overflow_clr2),
      .sample_l(sample_l2), .sample_r(sample_r2), .sample_valid(sample_valid2),
      .fifo_level(fifo_level2), .overflow(overflow2)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Left frame ends (rise), then right frame ends (fall); returns at the
   // negedge after the fall posedge, when the pushed pair is visible.
   task automatic send_raw(input logic [32:0] l, input logic [32:0] r,
                           input logic rdy, input logic clr2_v);
      SADCL  = l;
      adc_lr = 1'b1;
      tick();
      tick();
      SADCR         = r;
      adc_lr        = 1'b0;
      sample_ready  = rdy;
      overflow_clr2 = clr2_v;
      tick();
      sample_ready  = 1'b0;
      overflow_clr2 = 1'b0;
   endtask

   task automatic send_frame(input logic [23:0] l, input logic [23:0] r);
      send_raw({1'b0, l, 8'hA5}, {1'b0, r, 8'h5A}, 1'b0, 1'b0);
   endtask

   task automatic pop_one();
      sample_ready = 1'b1;
      tick();
      sample_ready = 1'b0;
   endtask

   initial begin
      enable        = 1'b0;
      adc_lr        = 1'b1;
      SADCL         = '0;
      SADCR         = '0;
      sample_ready  = 1'b0;
      overflow_clr  = 1'b0;
      sample_ready2 = 1'b0;
      overflow_clr2 = 1'b0;
      repeat (3) tick();

      // Reset state
      check("rst_valid", 64'(sample_valid), 64'd0);
      check("rst_level", 64'(fifo_level), 64'd0);
      check("rst_l", 64'(sample_l), 64'd0);
      check("rst_r", 64'(sample_r), 64'd0);
      check("rst_ovf", 64'(overflow), 64'd0);

      // Released during a right frame: that frame's fall only arms, no push
      enable = 1'b1;
      tick();
      tick();
      SADCR  = {1'b0, 24'hDEAD00, 8'h00};
      adc_lr = 1'b0;
      tick();
      check("t1_nopush_level", 64'(fifo_level), 64'd0);
      check("t1_nopush_valid", 64'(sample_valid), 64'd0);
      tick();
      send_frame(24'h123456, 24'hABCDEF);
      check("t1_l", 64'(sample_l), 64'h123456);
      check("t1_r", 64'(sample_r), 64'hABCDEF);
      check("t1_valid", 64'(sample_valid), 64'd1);
      check("t1_level", 64'(fifo_level), 64'd1);
      pop_one();
      check("t1_pop_level", 64'(fifo_level), 64'd0);

      // Five frames with no consumer: fifth is dropped and flagged
      for (int i = 1; i <= 5; i++) begin
         send_frame(24'(i), 24'(i * 'h11));
         check("t2_level", 64'(fifo_level), (i < 4) ? 64'(i) : 64'd4);
         check("t2_ovf", 64'(overflow), (i == 5) ? 64'd1 : 64'd0);
      end
      check("t2_head", {16'd0, sample_l, sample_r}, {16'd0, 24'd1, 24'h11});
      for (int k = 1; k <= 4; k++) begin
         check("t2_pop_order", {16'd0, sample_l, sample_r}, {16'd0, 24'(k), 24'(k * 'h11)});
         pop_one();
      end
      check("t2_empty", 64'(sample_valid), 64'd0);
      overflow_clr = 1'b1;
      tick();
      overflow_clr = 1'b0;
      check("t2_ovf_clr", 64'(overflow), 64'd0);

      // Push into a full FIFO while popping in the same cycle
      for (int i = 1; i <= 4; i++) begin
         send_frame(24'(32'h20 + i), 24'(32'h30 + i));
         exp_q.push_back({24'(32'h20 + i), 24'(32'h30 + i)});
      end
      check("t3_full", 64'(fifo_level), 64'd4);
      send_raw({1'b0, 24'd6, 8'h00}, {1'b0, 24'h66, 8'h00}, 1'b1, 1'b0);
      void'(exp_q.pop_front());
      exp_q.push_back({24'd6, 24'h66});
      check("t3_level", 64'(fifo_level), 64'd4);
      check("t3_ovf", 64'(overflow), 64'd0);
      while (exp_q.size() > 0) begin
         check("t3_drain", {16'd0, sample_l, sample_r}, {16'd0, exp_q.pop_front()});
         pop_one();
      end
      check("t3_empty", 64'(fifo_level), 64'd0);

      // Reset mid left frame with three pairs stored
      for (int i = 1; i <= 3; i++) begin
         send_frame(24'(32'h40 + i), 24'(32'h50 + i));
      end
      check("t4_pre_level", 64'(fifo_level), 64'd3);
      tick();
      enable = 1'b0;
      #1;
      check("t4_valid", 64'(sample_valid), 64'd0);
      check("t4_level", 64'(fifo_level), 64'd0);
      check("t4_l", 64'(sample_l), 64'd0);
      check("t4_r", 64'(sample_r), 64'd0);
      tick();
      adc_lr = 1'b1;
      tick();
      enable = 1'b1;
      tick();
      SADCR  = {1'b0, 24'h999999, 8'h00};
      adc_lr = 1'b0;
      tick();
      check("t4_discard", 64'(fifo_level), 64'd0);
      send_frame(24'h000061, 24'h000071);
      check("t4_first", {16'd0, sample_l, sample_r}, {16'd0, 24'h61, 24'h71});
      check("t4_level1", 64'(fifo_level), 64'd1);

      // 16-bit slice and clear-vs-drop priority on the depth-2 instance
      enable = 1'b0;
      adc_lr = 1'b1;
      tick();
      enable = 1'b1;
      tick();
      adc_lr = 1'b0;
      tick();
      send_raw(33'h0_8001_FFFF, 33'h0_7FFE_0000, 1'b0, 1'b0);
      check("t5_l16", 64'(sample_l2), 64'h8001);
      check("t5_r16", 64'(sample_r2), 64'h7FFE);
      check("t5_level16", 64'(fifo_level2), 64'd1);
      check("t5_l24", 64'(sample_l), 64'h8001FF);
      check("t5_r24", 64'(sample_r), 64'h7FFE00);
      send_raw(33'h0_1111_0000, 33'h0_2222_0000, 1'b0, 1'b0);
      check("t5_full16", 64'(fifo_level2), 64'd2);
      check("t5_ovf16_pre", 64'(overflow2), 64'd0);
      send_raw(33'h0_3333_0000, 33'h0_4444_0000, 1'b0, 1'b1);
      check("t5_ovf16_set_wins", 64'(overflow2), 64'd1);
      check("t5_level16_kept", 64'(fifo_level2), 64'd2);
      check("t5_head16_kept", 64'(sample_l2), 64'h8001);
      overflow_clr2 = 1'b1;
      tick();
      overflow_clr2 = 1'b0;
      check("t5_ovf16_clr", 64'(overflow2), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
